cam_axis_sequencer: RTL and testbench

Sequences the camera capture FIFO's read side into an AXI4-Stream video master for the HDMI/VDMA path. It pops 18-bit words {vsync, href, pixel[15:0]} from the first-word-fall-through capture FIFO and locks to frame and line boundaries. It emits exactly H_ACTIVE × V_ACTIVE pixels per frame, with tuser on the first pixel and tlast on each line end. It replaces ad-hoc always-read FIFO draining in the top level and owns all frame-sync error recovery.

---
 rtl/cam_pkg.sv | 31 +++
 rtl/axis_out_reg.sv | 39 +++
 rtl/cam_axis_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_cam_axis_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture FIFO to AXI4-Stream sequencer.
package cam_pkg;

    localparam int unsigned WORD_W    = 18;
    localparam int unsigned PIXEL_W   = 16;
    localparam int unsigned CNT_W     = 12;
    localparam int unsigned VSYNC_BIT = 17;
    localparam int unsigned HREF_BIT  = 16;
    localparam int unsigned PIXEL_MSB = 15;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_VBLANK = 2'd2;
    localparam logic [1:0] ST_FRAME  = 2'd3;

    typedef struct packed {
        logic               vsync;
        logic               href;
        logic [PIXEL_W-1:0] pixel;
    } fifo_word_t;

    typedef struct packed {
        logic               user;
        logic               last;
        logic [PIXEL_W-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI4-Stream output register; payload holds until the downstream handshake.
module axis_out_reg
    import cam_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  axis_beat_t         i_beat,
    input  logic               i_tready,
    output logic               o_tvalid,
    output logic [PIXEL_W-1:0] o_tdata,
    output logic               o_tuser,
    output logic               o_tlast,
    output logic               o_ready_for_load
);

    logic       r_valid;
    axis_beat_t r_beat;

    assign o_ready_for_load = !r_valid || i_tready;
    assign o_tvalid         = r_valid;
    assign o_tdata          = r_beat.data;
    assign o_tuser          = r_beat.user;
    assign o_tlast          = r_beat.last;

    // A load in the same cycle as a handshake replaces the beat with no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_beat  <= i_beat;
        end else if (i_tready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cam_axis_sequencer.sv
// Drains the FWFT capture FIFO, locks to vsync/href framing and emits exactly
// H_ACTIVE x V_ACTIVE pixels per frame on an AXI4-Stream master.
module cam_axis_sequencer
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               err_clear,
    input  logic [WORD_W-1:0]  fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    output logic [PIXEL_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               frame_done,
    output logic               err_line,
    output logic               err_frame
);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_ACTIVE);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_in_line;
    logic             r_line_full;
    logic             r_frame_done;
    logic             r_err_line;
    logic             r_err_frame;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_x_nxt;
    logic [CNT_W-1:0] w_y_nxt;
    logic             w_in_line_nxt;
    logic             w_line_full_nxt;
    logic             w_frame_done_nxt;
    logic             w_err_line_nxt;
    logic             w_err_frame_nxt;
    logic             w_set_err_line;
    logic             w_set_err_frame;

    fifo_word_t       w_word;
    axis_beat_t       w_beat;
    logic             w_vblank_go;
    logic             w_frame_word;
    logic [CNT_W-1:0] w_fx;
    logic [CNT_W-1:0] w_fy;
    logic             w_fin;
    logic             w_ffull;
    logic             w_line_start;
    logic             w_line_cont;
    logic             w_emit;
    logic             w_pop;
    logic             w_load;
    logic             w_ready_for_load;

    assign w_word = '{vsync: fifo_dout[VSYNC_BIT],
                      href:  fifo_dout[HREF_BIT],
                      pixel: fifo_dout[PIXEL_MSB:0]};

    // The first non-vsync word in VBLANK is handled as a FRAME word with fresh counters.
    assign w_vblank_go  = (r_state == ST_VBLANK) && enable && !w_word.vsync;
    assign w_frame_word = (r_state == ST_FRAME) || w_vblank_go;
    assign w_fx         = w_vblank_go ? '0   : r_x;
    assign w_fy         = w_vblank_go ? '0   : r_y;
    assign w_fin        = w_vblank_go ? 1'b0 : r_in_line;
    assign w_ffull      = w_vblank_go ? 1'b0 : r_line_full;

    assign w_line_start = w_frame_word && !w_word.vsync && w_word.href
                          && !w_fin && (w_fy < V_MAX);
    assign w_line_cont  = w_frame_word && !w_word.vsync && w_word.href
                          && w_fin && !w_ffull && (w_fx < H_MAX);
    assign w_emit       = w_line_start || w_line_cont;

    // Discarded words always pop; emitted words wait for room in the output register.
    assign w_pop      = !fifo_empty && (!w_emit || w_ready_for_load);
    assign w_load     = w_pop && w_emit;
    assign fifo_rd_en = reset_n && w_pop;

    assign w_beat = '{user: (w_fx == '0) && (w_fy == '0),
                      last: (w_fx == X_LAST),
                      data: w_word.pixel};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_in_line    <= 1'b0;
            r_line_full  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_line   <= 1'b0;
            r_err_frame  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_in_line    <= w_in_line_nxt;
            r_line_full  <= w_line_full_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err_line   <= w_err_line_nxt;
            r_err_frame  <= w_err_frame_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_in_line_nxt    = r_in_line;
        w_line_full_nxt  = r_line_full;
        w_frame_done_nxt = 1'b0;
        w_set_err_line   = 1'b0;
        w_set_err_frame  = 1'b0;
        w_err_line_nxt   = r_err_line;
        w_err_frame_nxt  = r_err_frame;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_pop && w_word.vsync) begin
                    w_state_nxt = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (w_pop && w_frame_word) begin
            w_state_nxt     = ST_FRAME;
            w_x_nxt         = w_fx;
            w_y_nxt         = w_fy;
            w_in_line_nxt   = w_fin;
            w_line_full_nxt = w_ffull;
            if (w_word.vsync) begin
                if (w_fy == V_MAX) begin
                    w_frame_done_nxt = 1'b1;
                end else begin
                    w_set_err_frame = 1'b1;
                end
                w_state_nxt = enable ? ST_VBLANK : ST_IDLE;
            end else if (w_word.href) begin
                if (w_emit) begin
                    w_in_line_nxt = 1'b1;
                    if (w_fx == X_LAST) begin
                        w_x_nxt         = '0;
                        w_y_nxt         = w_fy + CNT_W'(1);
                        w_line_full_nxt = 1'b1;
                    end else begin
                        w_x_nxt = w_fx + CNT_W'(1);
                    end
                end else if (w_fin) begin
                    w_set_err_line = 1'b1;
                end else begin
                    w_set_err_frame = 1'b1;
                end
            end else if (w_fin) begin
                if (!w_ffull) begin
                    w_set_err_line = 1'b1;
                    w_state_nxt    = ST_SYNC;
                end else begin
                    w_in_line_nxt   = 1'b0;
                    w_line_full_nxt = 1'b0;
                end
            end
        end

        if (err_clear) begin
            w_err_line_nxt  = 1'b0;
            w_err_frame_nxt = 1'b0;
        end else begin
            if (w_set_err_line) begin
                w_err_line_nxt = 1'b1;
            end
            if (w_set_err_frame) begin
                w_err_frame_nxt = 1'b1;
            end
        end
    end

    assign frame_done = r_frame_done;
    assign err_line   = r_err_line;
    assign err_frame  = r_err_frame;

    axis_out_reg u_out (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_load           (w_load),
        .i_beat           (w_beat),
        .i_tready         (m_axis_tready),
        .o_tvalid         (m_axis_tvalid),
        .o_tdata          (m_axis_tdata),
        .o_tuser          (m_axis_tuser),
        .o_tlast          (m_axis_tlast),
        .o_ready_for_load (w_ready_for_load)
    );

endmodule

// File: tb/tb_cam_axis_sequencer.sv
// Self-checking bench for cam_axis_sequencer against a line/frame level model.
module tb_cam_axis_sequencer;

    localparam int H = 4;
    localparam int V = 3;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic        err_clear = 1'b0;
    logic [17:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tuser;
    logic        tlast;
    logic        frame_done;
    logic        err_line;
    logic        err_frame;

    int checks   = 0;
    int failures = 0;

    logic [17:0] fq[$];
    logic [17:0] got[$];
    logic [17:0] exp_q[$];
    int          lens[$];
    int          done_cnt  = 0;
    int          exp_done  = 0;
    bit          e_line    = 1'b0;
    bit          e_frame   = 1'b0;
    int          tr_mode   = 0;
    int          cyc       = 0;
    int          seq       = 1;
    bit          bubbles   = 1'b0;
    bit          bp_check  = 1'b0;
    bit          pend_pop  = 1'b0;
    bit          pend_beat = 1'b0;
    bit          pend_stall = 1'b0;
    logic [17:0] snap      = '0;

    always #5 clk = ~clk;

    cam_axis_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .err_clear     (err_clear),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast),
        .frame_done    (frame_done),
        .err_line      (err_line),
        .err_frame     (err_frame)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // FIFO model, sink and handshake monitor; effects of each rising edge are applied at the next falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pend_pop && fq.size() > 0) void'(fq.pop_front());
            if (pend_beat) got.push_back(snap);
            if (pend_stall) begin
                chk("hold_tvalid", 32'(tvalid), 32'(1));
                chk("hold_beat", 32'({tuser, tlast, tdata}), 32'(snap));
            end
            if (frame_done) done_cnt++;
        end
        pend_pop   = 1'b0;
        pend_beat  = 1'b0;
        pend_stall = 1'b0;
        cyc++;
        case (tr_mode)
            0:       tready = 1'b1;
            1:       tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       tready = 1'($urandom_range(1, 0));
            default: tready = 1'b0;
        endcase
        fifo_empty = (fq.size() == 0) || (bubbles && ($urandom_range(3, 0) == 0));
        fifo_dout  = (fq.size() > 0) ? fq[0] : 18'h0;
        #1;
        if (reset_n) begin
            pend_pop   = fifo_rd_en;
            pend_beat  = tvalid && tready;
            pend_stall = tvalid && !tready;
            snap       = {tuser, tlast, tdata};
            if (bp_check && tvalid && !tready && fifo_rd_en)
                chk("no_pop_href_while_stalled", 32'(fifo_dout[16]), 32'(0));
        end
    end

    // Pushes one frame (optional leading vsync burst, lines of lens[] pixels) and models its output.
    task automatic push_frame(input bit lead, input bit modeled, input bit seqpx);
        logic [15:0] px[$];
        logic [15:0] v;
        int k;
        int y;
        int n;
        int len;
        bit ab;
        k  = 0;
        y  = 0;
        ab = 1'b0;
        if (lead) repeat ($urandom_range(3, 2)) fq.push_back({2'b10, 16'($urandom)});
        for (int li = 0; li < lens.size(); li++) begin
            repeat ($urandom_range(3, 1)) fq.push_back({2'b00, 16'($urandom)});
            for (int p = 0; p < lens[li]; p++) begin
                if (seqpx) begin
                    v = 16'(seq);
                    seq++;
                end else begin
                    v = 16'($urandom);
                end
                px.push_back(v);
                fq.push_back({2'b01, v});
            end
        end
        fq.push_back({2'b00, 16'($urandom)});
        if (modeled) begin
            for (int li = 0; li < lens.size() && !ab; li++) begin
                len = lens[li];
                if (y == V) begin
                    e_frame = 1'b1;
                end else begin
                    n = (len < H) ? len : H;
                    for (int p = 0; p < n; p++)
                        exp_q.push_back({1'(y == 0 && p == 0), 1'(p == H - 1), px[k + p]});
                    if (len < H) begin
                        e_line = 1'b1;
                        ab     = 1'b1;
                    end else begin
                        if (len > H) e_line = 1'b1;
                        y++;
                    end
                end
                k += len;
            end
            if (!ab) begin
                if (y == V) exp_done++;
                else e_frame = 1'b1;
            end
        end
    endtask

    task automatic push_term();
        repeat (2) fq.push_back({2'b10, 16'($urandom)});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((fq.size() != 0 || tvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_drain_in_budget"}, 32'(n < 3000), 32'(1));
    endtask

    task automatic compare(input string tag);
        int m;
        chk({tag, "_beat_count"}, 32'(got.size()), 32'(exp_q.size()));
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_beat%0d_user_last_data", tag, i), 32'(got[i]), 32'(exp_q[i]));
        chk({tag, "_frame_done_pulses"}, 32'(done_cnt), 32'(exp_done));
        chk({tag, "_err_line"}, 32'(err_line), 32'(e_line));
        chk({tag, "_err_frame"}, 32'(err_frame), 32'(e_frame));
        got.delete();
        exp_q.delete();
        done_cnt = 0;
        exp_done = 0;
    endtask

    task automatic pulse_clear(input string tag);
        @(negedge clk);
        #2 err_clear = 1'b1;
        @(negedge clk);
        #2 err_clear = 1'b0;
        chk({tag, "_err_line_cleared"}, 32'(err_line), 32'(0));
        chk({tag, "_err_frame_cleared"}, 32'(err_frame), 32'(0));
        e_line  = 1'b0;
        e_frame = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit seqpx);
        push_frame(1'b1, 1'b1, seqpx);
        push_term();
        drain(tag);
        compare(tag);
        pulse_clear(tag);
    endtask

    initial begin
        int r;
        int nl;
        int wait_n;
        bit saw_valid;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("reset_tvalid", 32'(tvalid), 32'(0));
        chk("reset_tdata", 32'(tdata), 32'(0));
        chk("reset_tuser", 32'(tuser), 32'(0));
        chk("reset_tlast", 32'(tlast), 32'(0));
        chk("reset_frame_done", 32'(frame_done), 32'(0));
        chk("reset_err_line", 32'(err_line), 32'(0));
        chk("reset_err_frame", 32'(err_frame), 32'(0));
        chk("reset_rd_en", 32'(fifo_rd_en), 32'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        enable = 1'b1;

        // Nominal 3 lines of 4 pixels, pixels 1..12
        tr_mode = 0;
        lens = '{4, 4, 4};
        seq = 1;
        run_frame("nominal", 1'b1);

        // Backpressure 1-0-0-1 with the same stimulus
        tr_mode  = 1;
        bp_check = 1'b1;
        seq = 1;
        run_frame("backpressure", 1'b1);
        bp_check = 1'b0;
        tr_mode  = 0;

        // Short line abandons the frame, then a clean frame follows
        lens = '{4, 3, 4};
        run_frame("short_line", 1'b0);
        lens = '{4, 4, 4};
        run_frame("after_short", 1'b0);

        // Long line, extra line, missing line
        lens = '{4, 6, 4};
        run_frame("long_line", 1'b0);
        lens = '{4, 4, 4, 4};
        run_frame("extra_line", 1'b0);
        lens = '{4, 4};
        run_frame("missing_line", 1'b0);

        // Random frames with FIFO bubbles and random tready
        bubbles = 1'b1;
        tr_mode = 2;
        for (int f = 0; f < 8; f++) begin
            r  = $urandom_range(5, 0);
            nl = (r == 0) ? 2 : ((r == 1) ? 4 : 3);
            lens.delete();
            for (int l = 0; l < nl; l++) begin
                r = $urandom_range(9, 0);
                lens.push_back((r == 0) ? 3 : ((r == 1) ? 5 : 4));
            end
            push_frame(1'b1, 1'b1, 1'b0);
        end
        push_term();
        drain("random");
        compare("random");
        pulse_clear("random");
        bubbles = 1'b0;
        tr_mode = 0;

        // Enable rises while href data of an unlocked frame is flowing
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        lens = '{4, 4, 4};
        push_frame(1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        push_frame(1'b1, 1'b1, 1'b0);
        push_term();
        drain("startup");
        chk("startup_first_beat_tuser", 32'(got.size() > 0 ? got[0][17] : 1'b0), 32'(1));
        compare("startup");
        pulse_clear("startup");

        // Reset while tvalid is held mid-line, then relock
        tr_mode = 3;
        push_frame(1'b1, 1'b0, 1'b0);
        wait_n = 0;
        while (!tvalid && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        saw_valid = tvalid;
        chk("reset_mid_line_tvalid_before", 32'(saw_valid), 32'(1));
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_tvalid", 32'(tvalid), 32'(0));
        chk("midreset_tdata", 32'(tdata), 32'(0));
        chk("midreset_tuser", 32'(tuser), 32'(0));
        chk("midreset_tlast", 32'(tlast), 32'(0));
        chk("midreset_rd_en", 32'(fifo_rd_en), 32'(0));
        fq.delete();
        got.delete();
        exp_q.delete();
        done_cnt = 0;
        exp_done = 0;
        e_line   = 1'b0;
        e_frame  = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tr_mode = 0;
        run_frame("relock", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
